// File: rtl/data_path.sv
// data_path: single-bus datapath with R0..R15, RA, Y/Z, PC, IR, HI, LO, MDR, PORT and a 64-bit ALU.
// Define MULDIV_EN to build the signed multiplier and divider; otherwise MUL/DIV give zero.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  ops,
  input  logic        Read,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        RAout,
  input  logic        RYout,
  input  logic        RZHIout,
  input  logic        RZLOout,
  input  logic        PCout,
  input  logic        IRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        PORTout,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        RAin,
  input  logic        RYin,
  input  logic        RZin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        MDRin,
  input  logic        PORTin
);

  logic [31:0] gpr_r [16];
  logic [31:0] ra_r, y_r, zhi_r, zlo_r, pc_r, ir_r, hi_r, lo_r, mdr_r, port_r;
  logic [15:0] gpr_out_s, gpr_in_s;
  logic [25:0] sel_s;
  logic [31:0] src_s [26];
  logic [31:0] bus_s;
  logic [63:0] alu_c_s;

  assign gpr_out_s = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign gpr_in_s  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  // Index order of sel_s/src_s is the bus priority order, lowest index wins
  assign sel_s = {PORTout, MDRout, LOout, HIout, IRout, PCout,
                  RZLOout, RZHIout, RYout, RAout, gpr_out_s};

`ifdef MULDIV_EN
  function automatic logic [63:0] mul_f(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mul_f = p;
  endfunction

  // Divide by -1 is handled apart so the most-negative dividend cannot overflow
  function automatic logic [63:0] div_f(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'd0) begin
      div_f = {a, 32'hFFFF_FFFF};
    end else if (b == 32'hFFFF_FFFF) begin
      div_f = {32'd0, 32'd0 - a};
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      div_f = {r, q};
    end
  endfunction
`endif

  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]  amt;
    logic [63:0] ror_w;
    logic [63:0] rol_w;
    logic [63:0] c;
    amt   = b[4:0];
    ror_w = {a, a} >> amt;
    rol_w = {a, a} << amt;
    c     = 64'd0;
    case (op)
      5'b00000: c[31:0] = a + b;
      5'b00001: c[31:0] = a - b;
      5'b00010: c[31:0] = a & b;
      5'b00011: c[31:0] = a | b;
      5'b00100: c[31:0] = a << amt;
      5'b00101: c[31:0] = a >> amt;
      5'b00110: c[31:0] = $signed(a) >>> amt;
      5'b00111: c[31:0] = ror_w[31:0];
      5'b01000: c[31:0] = rol_w[63:32];
`ifdef MULDIV_EN
      5'b01001: c = mul_f(a, b);
      5'b01010: c = div_f(a, b);
`endif
      5'b01011: c[31:0] = 32'd0 - b;
      5'b01100: c[31:0] = ~b;
      default:  c = 64'd0;
    endcase
    alu_f = c;
  endfunction

  // Collect every bus source into one array for the priority mux
  always_comb begin
    for (int i = 0; i < 16; i++) src_s[i] = gpr_r[i];
    src_s[16] = ra_r;
    src_s[17] = y_r;
    src_s[18] = zhi_r;
    src_s[19] = zlo_r;
    src_s[20] = pc_r;
    src_s[21] = ir_r;
    src_s[22] = hi_r;
    src_s[23] = lo_r;
    src_s[24] = mdr_r;
    src_s[25] = port_r;
  end

  // Scan from lowest to highest priority so the first asserted strobe ends up on the bus
  always_comb begin
    bus_s = 32'd0;
    for (int i = 25; i >= 0; i--) bus_s = sel_s[i] ? src_s[i] : bus_s;
  end

  // ALU: A is Y, B is the bus
  always_comb begin
    alu_c_s = alu_f(ops, y_r, bus_s);
  end

  // Register file and special registers; clear wipes everything immediately
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) gpr_r[i] <= 32'd0;
      ra_r   <= 32'd0;
      y_r    <= 32'd0;
      zhi_r  <= 32'd0;
      zlo_r  <= 32'd0;
      pc_r   <= 32'd0;
      ir_r   <= 32'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      mdr_r  <= 32'd0;
      port_r <= 32'd0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gpr_in_s[i]) gpr_r[i] <= bus_s;
      end
      if (RAin)   ra_r   <= bus_s;
      if (RYin)   y_r    <= bus_s;
      if (PCin)   pc_r   <= bus_s;
      if (IRin)   ir_r   <= bus_s;
      if (HIin)   hi_r   <= bus_s;
      if (LOin)   lo_r   <= bus_s;
      if (PORTin) port_r <= bus_s;
      if (MDRin)  mdr_r  <= Read ? Mdatain : bus_s;
      if (RZin) begin
        zhi_r <= alu_c_s[63:32];
        zlo_r <= alu_c_s[31:0];
      end
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed ALU table, random ALU ops against an
// arithmetic reference model, and hand sequences for bus priority, latency and reset.
module tb_data_path;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] mdat = 32'd0;
  logic [4:0]  op_t = 5'd0;
  logic        rd = 1'b0;
  logic [25:0] ov = '0;   // 0-15 R, 16 RA, 17 RY, 18 RZHI, 19 RZLO, 20 PC, 21 IR, 22 HI, 23 LO, 24 MDR, 25 PORT
  logic [24:0] iv = '0;   // 0-15 R, 16 RA, 17 RY, 18 RZ, 19 PC, 20 IR, 21 HI, 22 LO, 23 MDR, 24 PORT

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear), .Mdatain(mdat), .ops(op_t), .Read(rd),
    .R0out(ov[0]), .R1out(ov[1]), .R2out(ov[2]), .R3out(ov[3]),
    .R4out(ov[4]), .R5out(ov[5]), .R6out(ov[6]), .R7out(ov[7]),
    .R8out(ov[8]), .R9out(ov[9]), .R10out(ov[10]), .R11out(ov[11]),
    .R12out(ov[12]), .R13out(ov[13]), .R14out(ov[14]), .R15out(ov[15]),
    .RAout(ov[16]), .RYout(ov[17]), .RZHIout(ov[18]), .RZLOout(ov[19]),
    .PCout(ov[20]), .IRout(ov[21]), .HIout(ov[22]), .LOout(ov[23]),
    .MDRout(ov[24]), .PORTout(ov[25]),
    .R0in(iv[0]), .R1in(iv[1]), .R2in(iv[2]), .R3in(iv[3]),
    .R4in(iv[4]), .R5in(iv[5]), .R6in(iv[6]), .R7in(iv[7]),
    .R8in(iv[8]), .R9in(iv[9]), .R10in(iv[10]), .R11in(iv[11]),
    .R12in(iv[12]), .R13in(iv[13]), .R14in(iv[14]), .R15in(iv[15]),
    .RAin(iv[16]), .RYin(iv[17]), .RZin(iv[18]), .PCin(iv[19]),
    .IRin(iv[20]), .HIin(iv[21]), .LOin(iv[22]), .MDRin(iv[23]), .PORTin(iv[24])
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [25:0] obit(input int k);
    obit = 26'd1 << k;
  endfunction

  function automatic logic [24:0] ibit(input int k);
    ibit = 25'd1 << k;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic [25:0] o, input logic [24:0] i, input logic [4:0] op);
    ov = o; iv = i; op_t = op; rd = 1'b0;
    tick();
    ov = '0; iv = '0; op_t = 5'd0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    ov = '0; iv = ibit(23); mdat = v; rd = 1'b1;
    tick();
    iv = '0; rd = 1'b0;
  endtask

  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_mdr(a);
    cyc(obit(24), ibit(17), 5'd0);
    load_mdr(b);
    cyc(obit(24), ibit(18), op);
  endtask

  // Reference ALU from arithmetic definitions: shifts as powers of two, division in 64-bit
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua, ub, p, m, r;
    longint sa, sb, q, rm;
    int n;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    m = 64'hFFFF_FFFF;
    n = b[4:0];
    p = 64'd1 << n;
    r = 64'd0;
    case (op)
      5'd0:  r = (ua + ub) & m;
      5'd1:  r = (ua - ub) & m;
      5'd2:  r = ua & ub;
      5'd3:  r = ua | ub;
      5'd4:  r = (ua * p) & m;
      5'd5:  r = ua / p;
      5'd6:  begin
               if (sa >= 0) q = sa / longint'(p);
               else q = -(((-sa) + longint'(p) - 1) / longint'(p));
               r = q & m;
             end
      5'd7:  r = ((ua / p) + (ua % p) * (64'd1 << (32 - n))) & m;
      5'd8:  begin
               p = 64'd1 << ((32 - n) % 32);
               r = ((ua / p) + (ua % p) * (64'd1 << (32 - ((32 - n) % 32)))) & m;
             end
`ifdef MULDIV_EN
      5'd9:  r = sa * sb;
      5'd10: begin
               if (ub == 0) r = {a, 32'hFFFF_FFFF};
               else begin
                 q = sa / sb;
                 rm = sa - q * sb;
                 r = ((rm & m) << 32) | (q & m);
               end
             end
`endif
      5'd11: r = (64'd0 - ub) & m;
      5'd12: r = ub ^ m;
      default: r = 64'd0;
    endcase
    ref_alu = r;
  endfunction

  vec_t tbl[18];
  logic [31:0] a, b;
  logic [4:0]  op;

  initial begin
    tbl[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000};
    tbl[1]  = '{5'd1,  32'h0000_0005, 32'h0000_0007, 64'h0000_0000_FFFF_FFFE};
    tbl[2]  = '{5'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000};
    tbl[3]  = '{5'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 64'h0000_0000_FFFF_F0F0};
    tbl[4]  = '{5'd4,  32'h0000_0001, 32'h0000_001F, 64'h0000_0000_8000_0000};
    tbl[5]  = '{5'd4,  32'h1234_5678, 32'h0000_0020, 64'h0000_0000_1234_5678};
    tbl[6]  = '{5'd5,  32'hFFFF_FFFD, 32'h0000_0004, 64'h0000_0000_0FFF_FFFF};
    tbl[7]  = '{5'd6,  32'h8000_0000, 32'h0000_0004, 64'h0000_0000_F800_0000};
    tbl[8]  = '{5'd7,  32'h1234_5678, 32'h0000_0008, 64'h0000_0000_7812_3456};
    tbl[9]  = '{5'd8,  32'h1234_5678, 32'h0000_0004, 64'h0000_0000_2345_6781};
    tbl[10] = '{5'd7,  32'h1234_5678, 32'h0000_0000, 64'h0000_0000_1234_5678};
    tbl[11] = '{5'd11, 32'hAAAA_AAAA, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    tbl[12] = '{5'd12, 32'h0000_0000, 32'h0F0F_0F0F, 64'h0000_0000_F0F0_F0F0};
    tbl[13] = '{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
`ifdef MULDIV_EN
    tbl[14] = '{5'd9,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
    tbl[15] = '{5'd10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    tbl[16] = '{5'd10, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF};
`else
    tbl[14] = '{5'd9,  32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0000_0000_0000};
    tbl[15] = '{5'd10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0000_0000_0000};
    tbl[16] = '{5'd10, 32'h0000_0007, 32'h0000_0000, 64'h0000_0000_0000_0000};
`endif
    tbl[17] = '{5'd31, 32'h1234_5678, 32'h0000_0001, 64'h0000_0000_0000_0000};

    // Reset, and strobes ignored while clear is low
    #3 clear = 1'b0;
    #1;
    check("reset_r3", {32'd0, dut.gpr_r[3]}, 64'd0);
    check("reset_z", {dut.zhi_r, dut.zlo_r}, 64'd0);
    check("reset_mdr", {32'd0, dut.mdr_r}, 64'd0);
    iv = ibit(23) | ibit(18) | ibit(3); mdat = 32'hDEAD_BEEF; rd = 1'b1; op_t = 5'd12;
    tick(); tick();
    check("held_mdr", {32'd0, dut.mdr_r}, 64'd0);
    check("held_z", {dut.zhi_r, dut.zlo_r}, 64'd0);
    iv = '0; rd = 1'b0; op_t = 5'd0;
    clear = 1'b1;
    tick();

    // Directed ALU table
    for (int k = 0; k < 18; k++) begin
      run_alu(tbl[k].op, tbl[k].a, tbl[k].b);
      check($sformatf("alu_tbl%0d", k), {dut.zhi_r, dut.zlo_r}, tbl[k].exp);
    end

    // Random ALU against the reference model
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (b == 32'hFFFF_FFFF && a == 32'h8000_0000) a = 32'h8000_0001;
      run_alu(op, a, b);
      check($sformatf("alu_rand%0d_op%0d", k, op), {dut.zhi_r, dut.zlo_r}, ref_alu(op, a, b));
    end

    // SHR / SHRA full register sequences with R2out and RYout both high
    for (int s = 0; s < 2; s++) begin
      load_mdr(32'hFFFF_FFFD);
      cyc(obit(24), ibit(17), 5'd0);
      load_mdr(32'h0000_0004);
      cyc(obit(24), ibit(2), 5'd0);
      cyc(obit(2) | obit(17), ibit(18), (s == 0) ? 5'd5 : 5'd6);
      cyc(obit(19), ibit(1), 5'd0);
      cyc(obit(18), ibit(21), 5'd0);
      check(s == 0 ? "shr_r1" : "shra_r1", {32'd0, dut.gpr_r[1]},
            s == 0 ? 64'h0FFF_FFFF : 64'hFFFF_FFFF);
      check(s == 0 ? "shr_hi" : "shra_hi", {32'd0, dut.hi_r}, 64'd0);
    end

    // Every special register round-trips through the bus
    for (int k = 0; k < 7; k++) begin
      int src_i, dst_o;
      case (k)
        0: begin src_i = 16; dst_o = 16; end
        1: begin src_i = 19; dst_o = 20; end
        2: begin src_i = 20; dst_o = 21; end
        3: begin src_i = 21; dst_o = 22; end
        4: begin src_i = 22; dst_o = 23; end
        5: begin src_i = 24; dst_o = 25; end
        default: begin src_i = 17; dst_o = 17; end
      endcase
      a = $urandom;
      load_mdr(a);
      cyc(obit(24), ibit(src_i), 5'd0);
      cyc(obit(dst_o), ibit(10), 5'd0);
      check($sformatf("path%0d", k), {32'd0, dut.gpr_r[10]}, {32'd0, a});
    end

    // Zero-latency bus, one-clock load latency
    load_mdr(32'hCAFE_0001);
    ov = obit(24); iv = ibit(12);
    #1;
    check("bus_comb", {32'd0, dut.bus_s}, 64'h0000_0000_CAFE_0001);
    check("pre_edge_r12", {32'd0, dut.gpr_r[12]}, 64'd0);
    tick();
    ov = '0; iv = '0;
    check("post_edge_r12", {32'd0, dut.gpr_r[12]}, 64'h0000_0000_CAFE_0001);

    // MDR loads from the bus when Read = 0
    cyc(obit(12), ibit(23), 5'd0);
    check("mdr_from_bus", {32'd0, dut.mdr_r}, 64'h0000_0000_CAFE_0001);

    // Same-edge read and write of R8: ALU sees the old value
    load_mdr(32'd5);
    cyc(obit(24), ibit(17), 5'd0);
    load_mdr(32'd3);
    cyc(obit(24), ibit(8), 5'd0);
    cyc(obit(8), ibit(8) | ibit(18), 5'd0);
    check("same_edge_z", {dut.zhi_r, dut.zlo_r}, 64'd8);
    check("same_edge_r8", {32'd0, dut.gpr_r[8]}, 64'd3);

    // Bus default and priority
    load_mdr(32'h0000_0055);
    cyc(obit(24), ibit(5), 5'd0);
    cyc('0, ibit(5), 5'd0);
    check("bus_default_r5", {32'd0, dut.gpr_r[5]}, 64'd0);
    load_mdr(32'h1111_1111);
    cyc(obit(24), ibit(1), 5'd0);
    load_mdr(32'h2222_2222);
    cyc(obit(1) | obit(24), ibit(7), 5'd0);
    check("bus_priority_r7", {32'd0, dut.gpr_r[7]}, 64'h0000_0000_1111_1111);

    // Mid-run reset between edges, with R3in held during reset
    load_mdr(32'h1234_5678);
    cyc(obit(24), ibit(3), 5'd0);
    check("r3_loaded", {32'd0, dut.gpr_r[3]}, 64'h0000_0000_1234_5678);
    #2 clear = 1'b0;
    #1;
    check("r3_async_clear", {32'd0, dut.gpr_r[3]}, 64'd0);
    ov = obit(24); iv = ibit(3);
    tick(); tick();
    check("r3_held_in_reset", {32'd0, dut.gpr_r[3]}, 64'd0);
    ov = '0; iv = '0;
    clear = 1'b1;
    load_mdr(32'h0000_ABCD);
    cyc(obit(24), ibit(3), 5'd0);
    check("r3_after_reset", {32'd0, dut.gpr_r[3]}, 64'h0000_0000_0000_ABCD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
